dmem_arb: RTL and testbench

Two-port arbiter that lets the SISC CPU and the program/data loader share the single-port data memory. Each requester presents a read or write with a req/gnt handshake. The block accepts one access at a time, drives the memory for one cycle and returns a one-cycle done pulse carrying read data. It sits between the CPU's memory-stage address/data path and the DMEM instance, replacing the direct CPU-to-DMEM connection.

---
 rtl/dmem_arb_if.sv | 48 ++++
 rtl/dmem_arb.sv | 130 +++++++++++++
 tb/tb_dmem_arb.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_if.sv
// Bundle of CPU, loader and data-memory signals around the DMEM arbiter.
// slave  : the arbiter's view (takes requests, drives the memory).
// master : the environment's view (requesters and the memory itself).
interface dmem_arb_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_done;
   logic [DW-1:0] cpu_rdata;

   logic          ldr_req;
   logic          ldr_we;
   logic [AW-1:0] ldr_addr;
   logic [DW-1:0] ldr_wdata;
   logic          ldr_lock;
   logic          ldr_gnt;
   logic          ldr_done;
   logic [DW-1:0] ldr_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_done, cpu_rdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
      output ldr_gnt, ldr_done, ldr_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_done, cpu_rdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
      input  ldr_gnt, ldr_done, ldr_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arb.sv
// Arbiter sharing the single-port DMEM between the CPU and the loader.
// One access in flight: grant (IDLE) -> memory strobe (ACCESS) -> done (RESP).
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   IDLE   | arbitrate; gnt is combinational, winner captured on edge
//   ACCESS | mem_en high, captured we/addr/wdata drive the memory
//   RESP   | owner's done pulse, read data forwarded from mem_rdata
module dmem_arb #(
   parameter int AW       = 16,
   parameter int DW       = 32,
   parameter int LOCK_MAX = 8
) (
   input  logic         clk,
   input  logic         rst,
   dmem_arb_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic       OWN_CPU    = 1'b0;
   localparam logic       OWN_LDR    = 1'b1;
   localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

   state_t        state_q, state_d;
   logic          owner_q, owner_d;      // owner of the most recent grant
   logic          lock_q, lock_d;        // ldr_lock seen at that grant
   logic [7:0]    lock_cnt_q, lock_cnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;

   logic          lock_active;
   logic          cpu_win;
   logic          ldr_win;

   // Arbitration and next-state/capture logic.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      lock_d     = lock_q;
      lock_cnt_d = lock_cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cpu_win    = 1'b0;
      ldr_win    = 1'b0;

      // Lock only persists while the loader keeps ldr_lock high after a locked grant.
      lock_active = (owner_q == OWN_LDR) && lock_q && bus.ldr_lock;

      if ((state_q == IDLE) && !rst) begin
         if (bus.cpu_req && bus.ldr_req) begin
            if (lock_active && (lock_cnt_q < LOCK_MAX_C)) begin
               ldr_win = 1'b1;
            end else if (owner_q == OWN_LDR) begin
               cpu_win = 1'b1;
            end else begin
               ldr_win = 1'b1;
            end
         end else begin
            cpu_win = bus.cpu_req;
            ldr_win = bus.ldr_req;
         end
      end

      case (state_q)
         IDLE: begin
            if (cpu_win) begin
               state_d    = ACCESS;
               owner_d    = OWN_CPU;
               lock_d     = 1'b0;
               lock_cnt_d = 8'd0;
               we_d       = bus.cpu_we;
               addr_d     = bus.cpu_addr;
               wdata_d    = bus.cpu_wdata;
            end else if (ldr_win) begin
               state_d    = ACCESS;
               owner_d    = OWN_LDR;
               lock_d     = bus.ldr_lock;
               we_d       = bus.ldr_we;
               addr_d     = bus.ldr_addr;
               wdata_d    = bus.ldr_wdata;
               if (!bus.ldr_lock) begin
                  lock_cnt_d = 8'd0;
               end else if (lock_cnt_q < LOCK_MAX_C) begin
                  lock_cnt_d = lock_cnt_q + 8'd1;
               end
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and capture registers; synchronous reset aborts any in-flight access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_LDR;
         lock_q     <= 1'b0;
         lock_cnt_q <= 8'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lock_q     <= lock_d;
         lock_cnt_q <= lock_cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign bus.cpu_gnt   = cpu_win;
   assign bus.ldr_gnt   = ldr_win;

   assign bus.mem_en    = (state_q == ACCESS);
   assign bus.mem_we    = (state_q == ACCESS) && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   // The memory returns read data in the cycle after the strobe, i.e. during RESP.
   assign bus.cpu_done  = (state_q == RESP) && (owner_q == OWN_CPU);
   assign bus.ldr_done  = (state_q == RESP) && (owner_q == OWN_LDR);
   assign bus.cpu_rdata = (bus.cpu_done && !we_q) ? bus.mem_rdata : '0;
   assign bus.ldr_rdata = (bus.ldr_done && !we_q) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a small behavioural data memory.
module tb_dmem_arb;
   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   dmem_arb_if #(.AW(16), .DW(32)) bus ();

   dmem_arb #(.AW(16), .DW(32), .LOCK_MAX(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   logic [31:0] mem_rdata_r = '0;
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
         else            mem_rdata_r <= mem[bus.mem_addr[7:0]];
      end
   end
   assign bus.mem_rdata = mem_rdata_r;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Wait (bounded) for a grant, then return just after the granting edge (ACCESS).
   task automatic wait_gnt(input string tag, input bit ldr);
      int n    = 0;
      bit seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         seen = ldr ? bus.ldr_gnt : bus.cpu_gnt;
         n++;
      end
      chk(tag, 64'(seen), 64'd1);
      step();
   endtask

   int gq[$];
   int gt[$];

   // Record the next n grants (0 = CPU, 1 = loader) and the cycle of each.
   task automatic collect(input string tag, input int n);
      int cyc = 0;
      gq.delete();
      gt.delete();
      while (gq.size() < n && cyc < n * 4 + 10) begin
         @(negedge clk);
         cyc++;
         if (bus.cpu_gnt && bus.ldr_gnt) chk({tag, "_both_gnt"}, 64'd1, 64'd0);
         if (bus.cpu_gnt) begin
            gq.push_back(0);
            gt.push_back(cyc);
         end else if (bus.ldr_gnt) begin
            gq.push_back(1);
            gt.push_back(cyc);
         end
      end
      chk({tag, "_count"}, 64'(gq.size()), 64'(n));
      step();
   endtask

   task automatic chk_seq(input string tag, input int exp_q[$]);
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("%s_%0d", tag, i), 64'(gq.size() > i ? gq[i] : -1), 64'(exp_q[i]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq2[$];
      int seq3[$];
      int seq4[$];

      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
      bus.ldr_lock = 0;

      // Reset: no grant while rst is high, everything zero afterwards.
      rst = 1'b1;
      step();
      bus.cpu_req = 1'b1;
      #1;
      chk("rst_no_gnt", 64'(bus.cpu_gnt), 64'd0);
      step();
      bus.cpu_req = 1'b0;
      rst = 1'b0;
      chk("rst_mem_en",    64'(bus.mem_en),    64'd0);
      chk("rst_mem_we",    64'(bus.mem_we),    64'd0);
      chk("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
      chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("rst_cpu_done",  64'(bus.cpu_done),  64'd0);
      chk("rst_ldr_done",  64'(bus.ldr_done),  64'd0);
      chk("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);

      // CPU write 0x0010 then read back.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = 16'h0010; bus.cpu_wdata = 32'hDEADBEEF;
      #1;
      chk("wr_gnt_g",     64'(bus.cpu_gnt), 64'd1);
      chk("wr_ldr_gnt_g", 64'(bus.ldr_gnt), 64'd0);
      step();
      bus.cpu_req = 1'b0;
      chk("wr_mem_en",    64'(bus.mem_en),    64'd1);
      chk("wr_mem_we",    64'(bus.mem_we),    64'd1);
      chk("wr_mem_addr",  64'(bus.mem_addr),  64'h0010);
      chk("wr_mem_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
      chk("wr_gnt_g1",    64'(bus.cpu_gnt),   64'd0);
      chk("wr_done_g1",   64'(bus.cpu_done),  64'd0);
      step();
      chk("wr_done_g2",   64'(bus.cpu_done),  64'd1);
      chk("wr_rdata_g2",  64'(bus.cpu_rdata), 64'd0);
      chk("wr_mem_en_g2", 64'(bus.mem_en),    64'd0);
      step();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
      wait_gnt("rd_gnt", 1'b0);
      bus.cpu_req = 1'b0;
      chk("rd_mem_en", 64'(bus.mem_en), 64'd1);
      chk("rd_mem_we", 64'(bus.mem_we), 64'd0);
      step();
      chk("rd_done",      64'(bus.cpu_done),  64'd1);
      chk("rd_rdata",     64'(bus.cpu_rdata), 64'hDEADBEEF);
      chk("rd_ldr_done",  64'(bus.ldr_done),  64'd0);
      chk("rd_ldr_rdata", 64'(bus.ldr_rdata), 64'd0);
      step();

      // Contention after reset: CPU first, then strict alternation every 3 cycles.
      do_reset();
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001;
      bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 16'h0002;
      collect("rr", 5);
      seq2 = '{0, 1, 0, 1, 0};
      chk_seq("rr", seq2);
      chk("rr_gap", 64'(gt.size() > 1 ? gt[1] - gt[0] : 0), 64'd3);

      // Lock: 8 loader grants in a row, one forced CPU turn, then loader again.
      bus.ldr_lock = 1'b1;
      collect("lock", 10);
      seq3 = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
      chk_seq("lock", seq3);

      // Lock released: round-robin resumes with the CPU.
      bus.ldr_lock = 1'b0;
      collect("unlock", 2);
      seq4 = '{0, 1};
      chk_seq("unlock", seq4);
      bus.cpu_req = 1'b0;
      bus.ldr_req = 1'b0;
      repeat (3) step();

      // Reset during the ACCESS cycle of a CPU read.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
      wait_gnt("ra_gnt", 1'b0);
      bus.cpu_req = 1'b0;
      chk("ra_mem_en_access", 64'(bus.mem_en), 64'd1);
      rst = 1'b1;
      step();
      chk("ra_mem_en",    64'(bus.mem_en),    64'd0);
      chk("ra_mem_we",    64'(bus.mem_we),    64'd0);
      chk("ra_cpu_done",  64'(bus.cpu_done),  64'd0);
      chk("ra_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
      chk("ra_mem_addr",  64'(bus.mem_addr),  64'd0);
      bus.cpu_req = 1'b1;
      #1;
      chk("ra_no_gnt_in_rst", 64'(bus.cpu_gnt), 64'd0);
      step();
      rst = 1'b0;
      wait_gnt("ra_regnt", 1'b0);
      bus.cpu_req = 1'b0;
      step();
      chk("ra_redone",  64'(bus.cpu_done),  64'd1);
      chk("ra_rerdata", 64'(bus.cpu_rdata), 64'hDEADBEEF);
      step();

      // Loader request arriving while a CPU write is in flight.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = 16'h0020; bus.cpu_wdata = 32'h12345678;
      wait_gnt("busy_cpu_gnt", 1'b0);
      bus.cpu_req = 1'b0;
      bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 16'h0020;
      #1;
      chk("busy_ldr_gnt_access", 64'(bus.ldr_gnt), 64'd0);
      step();
      chk("busy_cpu_done",     64'(bus.cpu_done), 64'd1);
      chk("busy_ldr_gnt_resp", 64'(bus.ldr_gnt),  64'd0);
      chk("busy_ldr_done_resp", 64'(bus.ldr_done), 64'd0);
      step();
      chk("busy_ldr_gnt_idle", 64'(bus.ldr_gnt), 64'd1);
      step();
      bus.ldr_req = 1'b0;
      chk("busy_ldr_mem_en", 64'(bus.mem_en), 64'd1);
      chk("busy_ldr_mem_we", 64'(bus.mem_we), 64'd0);
      step();
      chk("busy_ldr_done",  64'(bus.ldr_done),  64'd1);
      chk("busy_ldr_rdata", 64'(bus.ldr_rdata), 64'h12345678);
      chk("busy_cpu_done2", 64'(bus.cpu_done),  64'd0);
      chk("busy_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
